// File: rtl/writeback_regfile.sv
// writeback_regfile: 16-entry register file with the writeback-stage source
// mux, same-cycle write bypass on both read ports, and a pending-write
// scoreboard that holds the decode stage on RAW and WAW hazards.
module writeback_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wre_writeback,
    input  logic                  select_writeback_data_mux_writeback,
    input  logic [3:0]            rd_writeback,
    input  logic [DATA_WIDTH-1:0] data_memory_writeback,
    input  logic [DATA_WIDTH-1:0] calc_data_writeback,
    input  logic                  issue_valid,
    input  logic                  issue_wre,
    input  logic [3:0]            issue_rd,
    input  logic [3:0]            rs1,
    input  logic [3:0]            rs2,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic [DATA_WIDTH-1:0] writeback_data,
    output logic                  stall,
    output logic [4:0]            pending_count
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [4:0]            pending_count_q, pending_count_d;

    logic                  wb_en;
    logic [NUM_REGS-1:0]   clear_vec, set_vec;
    logic                  rs1_hazard, rs2_hazard, waw_hazard;

    // A write to R0 is a no-op everywhere: data, bypass and scoreboard.
    assign wb_en = wre_writeback && (rd_writeback != 4'd0);

    // Writeback source mux: load data or ALU result.
    assign writeback_data = select_writeback_data_mux_writeback ? data_memory_writeback
                                                                 : calc_data_writeback;

    // Read ports: R0 hardwired to zero, then bypass, then the array.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        rs1_data = regs_q[rs1];
        rs2_data = regs_q[rs2];
        if (wb_en && (rd_writeback == rs1)) rs1_data = writeback_data;
        if (wb_en && (rd_writeback == rs2)) rs2_data = writeback_data;
        if (rs1 == 4'd0) rs1_data = '0;
        if (rs2 == 4'd0) rs2_data = '0;
    end

    // Hazard detection: a pending bit being cleared this cycle no longer blocks.
    always_comb begin
        rs1_hazard = (rs1 != 4'd0) && pending_q[rs1] && !(wb_en && (rd_writeback == rs1));
        rs2_hazard = (rs2 != 4'd0) && pending_q[rs2] && !(wb_en && (rd_writeback == rs2));
        waw_hazard = issue_wre && (issue_rd != 4'd0) && pending_q[issue_rd]
                     && !(wb_en && (rd_writeback == issue_rd));
        stall      = issue_valid && (rs1_hazard || rs2_hazard || waw_hazard);
    end

    // Scoreboard next state: clear on writeback, set on accepted issue; set wins.
    always_comb begin
        clear_vec = '0;
        set_vec   = '0;
        if (wb_en) clear_vec[rd_writeback] = 1'b1;
        if (issue_valid && issue_wre && (issue_rd != 4'd0) && !stall) set_vec[issue_rd] = 1'b1;
        pending_d = (pending_q & ~clear_vec) | set_vec;
        pending_count_d = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            pending_count_d = pending_count_d + {4'd0, pending_d[i]};
        end
    end

    // Scoreboard and its population count, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is assigned with <= so all flops sample the same pre-edge values.
        if (!reset) begin
            pending_q       <= '0;
            pending_count_q <= '0;
        end else begin
            pending_q       <= pending_d;
            pending_count_q <= pending_count_d;
        end
    end

    // Register array write port.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the array is reset because architectural state must read 0 after reset.
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_en) begin
            regs_q[rd_writeback] <= writeback_data;
        end
    end

    assign pending_count = pending_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, write/read, bypass, R0,
// RAW stall, WAW with same-edge set/clear, and mid-cycle reset.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        wre_writeback;
    logic        select_writeback_data_mux_writeback;
    logic [3:0]  rd_writeback;
    logic [15:0] data_memory_writeback;
    logic [15:0] calc_data_writeback;
    logic        issue_valid;
    logic        issue_wre;
    logic [3:0]  issue_rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic [15:0] writeback_data;
    logic        stall;
    logic [4:0]  pending_count;

    int errors = 0;
    int checks = 0;

    writeback_regfile #(.DATA_WIDTH(16), .NUM_REGS(16)) dut (
        .clk                                 (clk),
        .reset                               (reset),
        .wre_writeback                       (wre_writeback),
        .select_writeback_data_mux_writeback (select_writeback_data_mux_writeback),
        .rd_writeback                        (rd_writeback),
        .data_memory_writeback               (data_memory_writeback),
        .calc_data_writeback                 (calc_data_writeback),
        .issue_valid                         (issue_valid),
        .issue_wre                           (issue_wre),
        .issue_rd                            (issue_rd),
        .rs1                                 (rs1),
        .rs2                                 (rs2),
        .rs1_data                            (rs1_data),
        .rs2_data                            (rs2_data),
        .writeback_data                      (writeback_data),
        .stall                               (stall),
        .pending_count                       (pending_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        wre_writeback = 1'b0;
        select_writeback_data_mux_writeback = 1'b0;
        rd_writeback = 4'd0;
        data_memory_writeback = 16'h0000;
        calc_data_writeback = 16'h0000;
        issue_valid = 1'b0;
        issue_wre = 1'b0;
        issue_rd = 4'd0;
        rs1 = 4'd0;
        rs2 = 4'd0;
    endtask

    // Advance past the next rising edge; outputs are then sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic writeback(input logic sel, input logic [3:0] rd,
                             input logic [15:0] mem, input logic [15:0] calc);
        wre_writeback = 1'b1;
        select_writeback_data_mux_writeback = sel;
        rd_writeback = rd;
        data_memory_writeback = mem;
        calc_data_writeback = calc;
    endtask

    task automatic issue(input logic [3:0] rd, input logic [3:0] s1, input logic [3:0] s2);
        issue_valid = 1'b1;
        issue_wre = 1'b1;
        issue_rd = rd;
        rs1 = s1;
        rs2 = s2;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        rs1 = 4'd1;
        rs2 = 4'd15;
        #2;
        checks++;
        if (pending_count !== 5'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", pending_count);
        end
        checks++;
        if (rs1_data !== 16'h0000 || rs2_data !== 16'h0000) begin
            errors++; $display("FAIL reset_reads got %h/%h want 0000/0000", rs1_data, rs2_data);
        end
        step();
        step();
        reset = 1'b1;
        idle();
        #1;
    endtask

    task automatic test_write_read();
        writeback(1'b0, 4'd5, 16'hDEAD, 16'h1234);
        #1;
        checks++;
        if (writeback_data !== 16'h1234) begin
            errors++; $display("FAIL mux_calc got %h want 1234", writeback_data);
        end
        step();
        idle();
        rs1 = 4'd5;
        #1;
        checks++;
        if (rs1_data !== 16'h1234) begin
            errors++; $display("FAIL read_r5 got %h want 1234", rs1_data);
        end
        checks++;
        if (pending_count !== 5'd0) begin
            errors++; $display("FAIL count_after_write got %0d want 0", pending_count);
        end
    endtask

    task automatic test_bypass();
        idle();
        writeback(1'b1, 4'd3, 16'hBEEF, 16'h0001);
        rs2 = 4'd3;
        #1;
        checks++;
        if (rs2_data !== 16'hBEEF) begin
            errors++; $display("FAIL bypass_rs2 got %h want beef", rs2_data);
        end
        step();
        idle();
        rs2 = 4'd3;
        #1;
        checks++;
        if (rs2_data !== 16'hBEEF) begin
            errors++; $display("FAIL stored_r3 got %h want beef", rs2_data);
        end
    endtask

    task automatic test_r0();
        idle();
        writeback(1'b0, 4'd0, 16'h0000, 16'hFFFF);
        rs1 = 4'd0;
        #1;
        checks++;
        if (rs1_data !== 16'h0000) begin
            errors++; $display("FAIL r0_bypass got %h want 0000", rs1_data);
        end
        step();
        idle();
        issue(4'd0, 4'd0, 4'd0);
        #1;
        checks++;
        if (rs1_data !== 16'h0000 || stall !== 1'b0) begin
            errors++; $display("FAIL r0_read got %h stall %b want 0000 stall 0", rs1_data, stall);
        end
        step();
        idle();
        #1;
        checks++;
        if (pending_count !== 5'd0) begin
            errors++; $display("FAIL r0_issue_count got %0d want 0", pending_count);
        end
    endtask

    task automatic test_raw_stall();
        idle();
        issue(4'd7, 4'd0, 4'd0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL raw_first_issue stall got %b want 0", stall);
        end
        step();
        issue(4'd8, 4'd7, 4'd0);
        #1;
        checks++;
        if (pending_count !== 5'd1 || stall !== 1'b1) begin
            errors++; $display("FAIL raw_hazard count %0d stall %b want 1 and 1", pending_count, stall);
        end
        step();
        #1;
        checks++;
        if (pending_count !== 5'd1 || stall !== 1'b1) begin
            errors++; $display("FAIL raw_hold count %0d stall %b want 1 and 1", pending_count, stall);
        end
        writeback(1'b0, 4'd7, 16'h0000, 16'h7777);
        #1;
        checks++;
        if (stall !== 1'b0 || rs1_data !== 16'h7777) begin
            errors++; $display("FAIL raw_release stall %b data %h want 0 and 7777", stall, rs1_data);
        end
        step();
        idle();
        rs1 = 4'd7;
        #1;
        checks++;
        if (pending_count !== 5'd1 || rs1_data !== 16'h7777) begin
            errors++; $display("FAIL raw_after count %0d data %h want 1 and 7777", pending_count, rs1_data);
        end
        writeback(1'b0, 4'd8, 16'h0000, 16'h8888);
        step();
        idle();
        #1;
        checks++;
        if (pending_count !== 5'd0) begin
            errors++; $display("FAIL raw_drain count got %0d want 0", pending_count);
        end
    endtask

    task automatic test_waw();
        idle();
        issue(4'd4, 4'd0, 4'd0);
        step();
        writeback(1'b0, 4'd4, 16'h0000, 16'h4444);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL waw_same_edge stall got %b want 0", stall);
        end
        step();
        idle();
        issue(4'd4, 4'd0, 4'd0);
        #1;
        checks++;
        if (pending_count !== 5'd1) begin
            errors++; $display("FAIL waw_set_wins count got %0d want 1", pending_count);
        end
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL waw_second_issue stall got %b want 1", stall);
        end
        idle();
        writeback(1'b0, 4'd4, 16'h0000, 16'h4445);
        step();
        idle();
        #1;
        checks++;
        if (pending_count !== 5'd0) begin
            errors++; $display("FAIL waw_drain count got %0d want 0", pending_count);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        for (int r = 1; r <= 3; r++) begin
            issue(r[3:0], 4'd0, 4'd0);
            step();
        end
        idle();
        #1;
        checks++;
        if (pending_count !== 5'd3) begin
            errors++; $display("FAIL mid_pending count got %0d want 3", pending_count);
        end
        reset = 1'b0;
        rs1 = 4'd5;
        rs2 = 4'd3;
        #1;
        checks++;
        if (pending_count !== 5'd0 || rs1_data !== 16'h0000 || rs2_data !== 16'h0000) begin
            errors++; $display("FAIL mid_reset count %0d reads %h/%h want 0 0000/0000",
                               pending_count, rs1_data, rs2_data);
        end
        issue(4'd9, 4'd1, 4'd2);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL mid_reset_stall got %b want 0", stall);
        end
        writeback(1'b0, 4'd9, 16'h0000, 16'h9999);
        step();
        idle();
        reset = 1'b1;
        rs1 = 4'd9;
        #1;
        checks++;
        if (rs1_data !== 16'h0000 || pending_count !== 5'd0) begin
            errors++; $display("FAIL reset_discard data %h count %0d want 0000 0", rs1_data, pending_count);
        end
        writeback(1'b0, 4'd9, 16'h0000, 16'hABCD);
        issue(4'd2, 4'd0, 4'd0);
        step();
        idle();
        rs1 = 4'd9;
        #1;
        checks++;
        if (rs1_data !== 16'hABCD || pending_count !== 5'd1) begin
            errors++; $display("FAIL post_reset_edge data %h count %0d want abcd 1", rs1_data, pending_count);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_raw_stall();
        test_waw();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
